// File: rtl/tv80_prefix_pkg.sv
// Shared types, prefix byte constants and the index-ignored opcode classifier
// for the TV80 opcode prefix sequencer.
package tv80_prefix_pkg;

    localparam int unsigned OP_W    = 8;
    localparam int unsigned CNT_W   = 4;
    localparam int unsigned CNT_MAX = 15;

    localparam logic [OP_W-1:0] PFX_DD = 8'hDD;
    localparam logic [OP_W-1:0] PFX_FD = 8'hFD;
    localparam logic [OP_W-1:0] PFX_ED = 8'hED;
    localparam logic [OP_W-1:0] PFX_CB = 8'hCB;

    typedef enum logic [2:0] {
        ST_IDLE, ST_IDX, ST_EDP, ST_CBP, ST_IXD, ST_IXO, ST_HOLD
    } state_e;

    typedef enum logic [1:0] {GRP_MAIN = 2'd0, GRP_CB = 2'd1, GRP_ED = 2'd2} group_e;
    typedef enum logic [1:0] {IDX_HL = 2'd0, IDX_IX = 2'd1, IDX_IY = 2'd2} idx_e;

    typedef struct packed {
        logic [OP_W-1:0]  opcode;
        group_e           group;
        idx_e             idx;
        logic [OP_W-1:0]  disp;
        logic [CNT_W-1:0] cnt;
        logic             undoc;
    } desc_t;

    function automatic logic reg_is_hl(input logic [2:0] r);
        return (r >= 3'd4) && (r <= 3'd6);
    endfunction

    // True when a main-group opcode touches H, L, HL or (HL); EB is deliberately excluded.
    function automatic logic uses_hl(input logic [OP_W-1:0] op);
        logic [2:0] y;
        logic [2:0] z;
        logic       hl;
        y  = op[5:3];
        z  = op[2:0];
        hl = 1'b0;
        case (op[7:6])
            2'd0: begin
                case (z)
                    3'd1:             hl = (y == 3'd4) || y[0];
                    3'd2, 3'd3:       hl = (y == 3'd4) || (y == 3'd5);
                    3'd4, 3'd5, 3'd6: hl = reg_is_hl(y);
                    default:          hl = 1'b0;
                endcase
            end
            2'd1:    hl = (op != 8'h76) && (reg_is_hl(y) || reg_is_hl(z));
            2'd2:    hl = reg_is_hl(z);
            default: hl = (op == 8'hE1) || (op == 8'hE3) || (op == 8'hE5) ||
                          (op == 8'hE9) || (op == 8'hF9);
        endcase
        return hl;
    endfunction

endpackage

// File: rtl/tv80_prefix_seq_fsm.sv
// Prefix-chain state machine: tracks where in a DD/FD/ED/CB chain the byte stream is.
module tv80_prefix_fsm
    import tv80_prefix_pkg::*;
(
    input  logic            clk_i,
    input  logic            reset_i,
    input  logic            flush_i,
    input  logic            xfer_i,
    input  logic [OP_W-1:0] op_i,
    input  logic            dec_ready_i,
    output state_e          state_o,
    output logic            op_ready_o,
    output logic            int_block_o
);

    state_e state_q, state_d;
    logic   op_ready_q;
    logic   int_block_q;
    logic   is_idx_pfx_c;

    assign is_idx_pfx_c = (op_i == PFX_DD) || (op_i == PFX_FD);

    always_comb begin
        state_d = state_q;
        if (flush_i) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: if (xfer_i) begin
                    if (is_idx_pfx_c)         state_d = ST_IDX;
                    else if (op_i == PFX_ED)  state_d = ST_EDP;
                    else if (op_i == PFX_CB)  state_d = ST_CBP;
                    else                      state_d = ST_HOLD;
                end
                ST_IDX: if (xfer_i) begin
                    if (is_idx_pfx_c)         state_d = ST_IDX;
                    else if (op_i == PFX_ED)  state_d = ST_EDP;
                    else if (op_i == PFX_CB)  state_d = ST_IXD;
                    else                      state_d = ST_HOLD;
                end
                ST_EDP, ST_CBP, ST_IXO: if (xfer_i) state_d = ST_HOLD;
                ST_IXD:  if (xfer_i)      state_d = ST_IXO;
                ST_HOLD: if (dec_ready_i) state_d = ST_IDLE;
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Ready and interrupt-block are registered decodes of the next state.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q     <= ST_IDLE;
            op_ready_q  <= 1'b1;
            int_block_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_ready_q  <= (state_d != ST_HOLD);
            int_block_q <= (state_d == ST_IDX) || (state_d == ST_EDP) || (state_d == ST_CBP) ||
                           (state_d == ST_IXD) || (state_d == ST_IXO);
        end
    end

    assign state_o     = state_q;
    assign op_ready_o  = op_ready_q;
    assign int_block_o = int_block_q;

endmodule

// File: rtl/tv80_prefix_seq.sv
// Opcode prefix sequencer: folds prefix chains into one registered descriptor.
// Optional TV80_UNDOC_FLAG_EN enables the o_undoc classification output.
module tv80_prefix_seq
    import tv80_prefix_pkg::*;
(
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_flush,
    input  logic             i_op_valid,
    input  logic [OP_W-1:0]  i_op,
    output logic             o_op_ready,
    output logic             o_valid,
    input  logic             i_dec_ready,
    output logic [OP_W-1:0]  o_opcode,
    output logic [1:0]       o_group,
    output logic [1:0]       o_idx,
    output logic [OP_W-1:0]  o_disp,
    output logic [CNT_W-1:0] o_prefix_cnt,
    output logic             o_undoc,
    output logic             o_int_block
);

`ifdef TV80_UNDOC_FLAG_EN
    localparam logic UNDOC_EN = 1'b1;
`else
    localparam logic UNDOC_EN = 1'b0;
`endif

    state_e           state;
    desc_t            desc_q, desc_d;
    logic             valid_q, valid_d;
    logic             xfer_c;
    logic             set_undoc_c;
    logic             is_idx_pfx_c;
    logic [CNT_W-1:0] cnt_inc_c;
    idx_e             idx_sel_c;

    assign xfer_c       = i_op_valid && o_op_ready;
    assign is_idx_pfx_c = (i_op == PFX_DD) || (i_op == PFX_FD);
    assign idx_sel_c    = (i_op == PFX_DD) ? IDX_IX : IDX_IY;
    assign cnt_inc_c    = (desc_q.cnt == CNT_W'(CNT_MAX)) ? desc_q.cnt : desc_q.cnt + CNT_W'(1);

    tv80_prefix_fsm u_fsm (
        .clk_i       (i_clk),
        .reset_i     (i_reset),
        .flush_i     (i_flush),
        .xfer_i      (xfer_c),
        .op_i        (i_op),
        .dec_ready_i (i_dec_ready),
        .state_o     (state),
        .op_ready_o  (o_op_ready),
        .int_block_o (o_int_block)
    );

    always_comb begin
        desc_d      = desc_q;
        valid_d     = valid_q;
        set_undoc_c = 1'b0;
        if (i_flush) begin
            desc_d  = '0;
            valid_d = 1'b0;
        end else if (state == ST_HOLD) begin
            if (i_dec_ready) begin
                desc_d  = '0;
                valid_d = 1'b0;
            end
        end else if (xfer_c) begin
            case (state)
                ST_IDLE, ST_IDX: begin
                    if (is_idx_pfx_c) begin
                        desc_d.idx  = idx_sel_c;
                        desc_d.cnt  = cnt_inc_c;
                        set_undoc_c = (state == ST_IDX);
                    end else if (i_op == PFX_ED) begin
                        desc_d.idx  = IDX_HL;
                        desc_d.cnt  = cnt_inc_c;
                        set_undoc_c = (state == ST_IDX);
                    end else if (i_op == PFX_CB) begin
                        desc_d.cnt  = cnt_inc_c;
                    end else begin
                        desc_d.opcode = i_op;
                        desc_d.group  = GRP_MAIN;
                        valid_d       = 1'b1;
                        // Index prefix has no effect on opcodes that never name H/L/HL.
                        if ((desc_q.idx != IDX_HL) && !uses_hl(i_op)) begin
                            desc_d.idx  = IDX_HL;
                            set_undoc_c = 1'b1;
                        end
                    end
                end
                ST_EDP: begin
                    desc_d.opcode = i_op;
                    desc_d.group  = GRP_ED;
                    valid_d       = 1'b1;
                end
                ST_CBP, ST_IXO: begin
                    desc_d.opcode = i_op;
                    desc_d.group  = GRP_CB;
                    valid_d       = 1'b1;
                end
                ST_IXD:  desc_d.disp = i_op;
                default: desc_d = desc_q;
            endcase
        end
        desc_d.undoc = UNDOC_EN && (desc_d.undoc || set_undoc_c);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            desc_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            desc_q  <= desc_d;
            valid_q <= valid_d;
        end
    end

    assign o_valid      = valid_q;
    assign o_opcode     = desc_q.opcode;
    assign o_group      = desc_q.group;
    assign o_idx        = desc_q.idx;
    assign o_disp       = desc_q.disp;
    assign o_prefix_cnt = desc_q.cnt;
    assign o_undoc      = desc_q.undoc;

endmodule

// File: tb/tb_tv80_prefix_seq.sv
// Self-checking bench for tv80_prefix_seq: directed scenarios plus randomized
// instruction streams checked against a parse-level reference model.
module tb_tv80_prefix_seq;

    typedef logic [7:0] bq_t[$];

    logic       i_clk = 1'b0;
    logic       i_reset, i_flush, i_op_valid, i_dec_ready;
    logic [7:0] i_op;
    logic       o_op_ready, o_valid, o_undoc, o_int_block;
    logic [7:0] o_opcode, o_disp;
    logic [1:0] o_group, o_idx;
    logic [3:0] o_prefix_cnt;

    int checks   = 0;
    int failures = 0;

    tv80_prefix_seq dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_flush(i_flush),
        .i_op_valid(i_op_valid), .i_op(i_op), .o_op_ready(o_op_ready),
        .o_valid(o_valid), .i_dec_ready(i_dec_ready), .o_opcode(o_opcode),
        .o_group(o_group), .o_idx(o_idx), .o_disp(o_disp),
        .o_prefix_cnt(o_prefix_cnt), .o_undoc(o_undoc), .o_int_block(o_int_block)
    );

    always #5 i_clk = ~i_clk;

    // {valid, opcode, group, idx, disp, prefix_cnt, undoc}
    wire [25:0] obs = {o_valid, o_opcode, o_group, o_idx, o_disp, o_prefix_cnt, o_undoc};

    function automatic logic [25:0] exp_vec(input logic [7:0] op, input int grp, input int idx,
                                            input logic [7:0] disp, input int cnt, input bit undoc);
        bit u;
`ifdef TV80_UNDOC_FLAG_EN
        u = undoc;
`else
        u = 1'b0;
`endif
        return {1'b1, op, 2'(grp), 2'(idx), disp, 4'(cnt), u};
    endfunction

    // Opcodes that name H, L, HL or (HL) in the main table (EX DE,HL excluded).
    function automatic bit names_hl(input logic [7:0] op);
        case (op) inside
            8'h09, 8'h19, 8'h21, 8'h22, 8'h23, 8'h24, 8'h25, 8'h26, 8'h29, 8'h2A,
            8'h2B, 8'h2C, 8'h2D, 8'h2E, 8'h34, 8'h35, 8'h36, 8'h39,
            8'hE1, 8'hE3, 8'hE5, 8'hE9, 8'hF9, [8'h60:8'h75], 8'h77: return 1'b1;
            [8'h40:8'hBF]: return (op[2:0] == 3'd4) || (op[2:0] == 3'd5) ||
                                  ((op[2:0] == 3'd6) && (op != 8'h76));
            default: return 1'b0;
        endcase
    endfunction

    // Parse a complete instruction byte string into its expected descriptor.
    function automatic logic [25:0] model(input bq_t b);
        int i = 0, idx = 0, nidx = 0, cnt, grp = 0;
        bit undoc = 0;
        logic [7:0] op, disp = 8'h00;
        while (b[i] == 8'hDD || b[i] == 8'hFD) begin
            idx = (b[i] == 8'hDD) ? 1 : 2;
            nidx++;
            i++;
        end
        cnt = nidx;
        if (nidx > 1) undoc = 1;
        if (b[i] == 8'hED) begin
            grp = 2; cnt++; op = b[i+1];
            if (nidx > 0) begin idx = 0; undoc = 1; end
        end else if (b[i] == 8'hCB) begin
            grp = 1; cnt++;
            if (nidx > 0) begin disp = b[i+1]; op = b[i+2]; end
            else op = b[i+1];
        end else begin
            op = b[i];
            if (idx != 0 && !names_hl(op)) begin idx = 0; undoc = 1; end
        end
        if (cnt > 15) cnt = 15;
        return exp_vec(op, grp, idx, disp, cnt, undoc);
    endfunction

    task automatic feed(input bq_t b);
        foreach (b[k]) begin
            i_op = b[k]; i_op_valid = 1'b1;
            @(posedge i_clk); #1;
        end
        i_op_valid = 1'b0;
    endtask

    task automatic accept();
        i_dec_ready = 1'b1;
        @(posedge i_clk); #1;
        i_dec_ready = 1'b0;
    endtask

    task automatic test_reset();
        i_reset = 1'b1; i_flush = 1'b0; i_op_valid = 1'b0; i_op = 8'h00; i_dec_ready = 1'b0;
        repeat (2) @(posedge i_clk);
        #1;
        checks++;
        if ({obs, o_op_ready, o_int_block} !== {26'd0, 1'b1, 1'b0}) begin
            failures++;
            $display("FAIL reset_state got=%h ready=%b ib=%b want=0 ready=1 ib=0", obs, o_op_ready, o_int_block);
        end
        i_reset = 1'b0;
    endtask

    task automatic test_index_prefix();
        logic [25:0] e;
        feed('{8'hFD});
        checks++;
        if (o_valid !== 1'b0 || o_int_block !== 1'b1) begin
            failures++;
            $display("FAIL fd_pending valid=%b ib=%b want valid=0 ib=1", o_valid, o_int_block);
        end
        feed('{8'h06});
        e = exp_vec(8'h06, 0, 0, 8'h00, 1, 1);
        checks++;
        if (obs !== e) begin failures++; $display("FAIL fd_06 got=%h want=%h", obs, e); end
        accept();
        feed('{8'hDD, 8'hFD, 8'h21});
        e = exp_vec(8'h21, 0, 2, 8'h00, 2, 1);
        checks++;
        if (obs !== e) begin failures++; $display("FAIL dd_fd_21 got=%h want=%h", obs, e); end
        accept();
        feed('{8'hFD, 8'h21});
        e = exp_vec(8'h21, 0, 2, 8'h00, 1, 0);
        checks++;
        if (obs !== e) begin failures++; $display("FAIL fd_21 got=%h want=%h", obs, e); end
        accept();
        feed('{8'hDD, 8'hEB});
        e = exp_vec(8'hEB, 0, 0, 8'h00, 1, 1);
        checks++;
        if (obs !== e) begin failures++; $display("FAIL dd_eb got=%h want=%h", obs, e); end
        accept();
    endtask

    task automatic test_indexed_cb();
        bq_t s = '{8'hDD, 8'hCB, 8'h05, 8'hC6};
        logic [25:0] e;
        for (int k = 0; k < 4; k++) begin
            i_op = s[k]; i_op_valid = 1'b1;
            @(posedge i_clk); #1;
            checks++;
            if (o_int_block !== (k < 3)) begin
                failures++;
                $display("FAIL ixcb_int_block byte=%0d got=%b want=%b", k, o_int_block, k < 3);
            end
        end
        i_op_valid = 1'b0;
        e = exp_vec(8'hC6, 1, 1, 8'h05, 2, 0);
        checks++;
        if (obs !== e) begin failures++; $display("FAIL dd_cb_05_c6 got=%h want=%h", obs, e); end
        accept();
    endtask

    task automatic test_ed_group();
        logic [25:0] e;
        feed('{8'hDD, 8'hED, 8'h44});
        e = exp_vec(8'h44, 2, 0, 8'h00, 2, 1);
        checks++;
        if (obs !== e) begin failures++; $display("FAIL dd_ed_44 got=%h want=%h", obs, e); end
        accept();
        feed('{8'hED, 8'hDD});
        e = exp_vec(8'hDD, 2, 0, 8'h00, 1, 0);
        checks++;
        if (obs !== e) begin failures++; $display("FAIL ed_dd got=%h want=%h", obs, e); end
        accept();
    endtask

    task automatic test_hold_stall();
        logic [25:0] e;
        feed('{8'h3E});
        e = exp_vec(8'h3E, 0, 0, 8'h00, 0, 0);
        for (int c = 0; c < 3; c++) begin
            i_op = 8'hDD; i_op_valid = 1'b1;
            @(posedge i_clk); #1;
            checks++;
            if (obs !== e || o_op_ready !== 1'b0) begin
                failures++;
                $display("FAIL hold_stall cyc=%0d got=%h ready=%b want=%h ready=0", c, obs, o_op_ready, e);
            end
        end
        i_op_valid = 1'b0;
        accept();
        checks++;
        if (o_valid !== 1'b0 || o_op_ready !== 1'b1) begin
            failures++;
            $display("FAIL hold_release valid=%b ready=%b want valid=0 ready=1", o_valid, o_op_ready);
        end
        feed('{8'h66});
        e = exp_vec(8'h66, 0, 0, 8'h00, 0, 0);
        checks++;
        if (obs !== e) begin failures++; $display("FAIL after_stall_66 got=%h want=%h", obs, e); end
        accept();
    endtask

    task automatic test_abort_midchain();
        logic [25:0] e;
        e = exp_vec(8'h66, 0, 0, 8'h00, 0, 0);
        feed('{8'hDD});
        i_reset = 1'b1;
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        feed('{8'h66});
        checks++;
        if (obs !== e) begin failures++; $display("FAIL reset_midchain got=%h want=%h", obs, e); end
        accept();
        // Flush wins over a byte offered in the same cycle.
        feed('{8'hDD});
        i_flush = 1'b1; i_op = 8'hFD; i_op_valid = 1'b1;
        @(posedge i_clk); #1;
        i_flush = 1'b0; i_op_valid = 1'b0;
        checks++;
        if (o_valid !== 1'b0 || o_int_block !== 1'b0 || o_prefix_cnt !== 4'd0) begin
            failures++;
            $display("FAIL flush_clear valid=%b ib=%b cnt=%0d want 0 0 0", o_valid, o_int_block, o_prefix_cnt);
        end
        feed('{8'h66});
        checks++;
        if (obs !== e) begin failures++; $display("FAIL flush_midchain got=%h want=%h", obs, e); end
        // Flush while holding a descriptor drops it.
        i_flush = 1'b1;
        @(posedge i_clk); #1;
        i_flush = 1'b0;
        checks++;
        if (o_valid !== 1'b0 || o_op_ready !== 1'b1) begin
            failures++;
            $display("FAIL flush_hold valid=%b ready=%b want valid=0 ready=1", o_valid, o_op_ready);
        end
    endtask

    task automatic test_saturation();
        bq_t q;
        logic [25:0] e;
        for (int k = 0; k < 17; k++) q.push_back(8'hDD);
        q.push_back(8'h21);
        e = model(q);
        feed(q);
        checks++;
        if (obs !== e || o_prefix_cnt !== 4'd15) begin
            failures++;
            $display("FAIL cnt_saturate got=%h want=%h", obs, e);
        end
        accept();
    endtask

    task automatic test_random();
        for (int n = 0; n < 80; n++) begin
            bq_t q;
            logic [25:0] e;
            logic [7:0] b;
            int nidx = $urandom_range(0, 3);
            int kind = $urandom_range(0, 2);
            for (int k = 0; k < nidx; k++) q.push_back($urandom_range(0, 1) ? 8'hDD : 8'hFD);
            if (kind == 1) begin
                q.push_back(8'hED); q.push_back(8'($urandom));
            end else if (kind == 2) begin
                q.push_back(8'hCB);
                if (nidx > 0) q.push_back(8'($urandom));
                q.push_back(8'($urandom));
            end else begin
                do b = 8'($urandom); while (b == 8'hDD || b == 8'hFD || b == 8'hED || b == 8'hCB);
                q.push_back(b);
            end
            e = model(q);
            feed(q);
            checks++;
            if (obs !== e) begin failures++; $display("FAIL rand_desc n=%0d got=%h want=%h", n, obs, e); end
            for (int s = $urandom_range(0, 2); s > 0; s--) begin
                i_op = 8'($urandom); i_op_valid = 1'b1;
                @(posedge i_clk); #1;
                checks++;
                if (obs !== e || o_op_ready !== 1'b0) begin
                    failures++;
                    $display("FAIL rand_stall n=%0d got=%h ready=%b want=%h", n, obs, o_op_ready, e);
                end
            end
            i_op_valid = 1'b0;
            accept();
            checks++;
            if (o_valid !== 1'b0 || o_op_ready !== 1'b1) begin
                failures++;
                $display("FAIL rand_accept n=%0d valid=%b ready=%b", n, o_valid, o_op_ready);
            end
        end
    endtask

    initial begin
        test_reset();
        test_index_prefix();
        test_indexed_cb();
        test_ed_group();
        test_hold_stall();
        test_abort_midchain();
        test_saturation();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
